gray_frame_ctrl: RTL and testbench
==================================

Name: gray_frame_ctrl

Overview:
Frame-level sequencer for the 4-stage RGB-to-grayscale converter. On a start pulse it streams every pixel of one frame from a synchronous-read source RAM into the converter with din_valid. It captures the converter's grayscale results and writes them to a destination RAM at matching addresses. It signals done when the last result is written, supports abort, and flushes the converter pipeline after reset and abort, since the converter has no reset.

Parameters:
IMG_WIDTH, 4, pixels per line
IMG_HEIGHT, 2, lines per frame
ADDR_WIDTH, 16, RAM address width; 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
PIPE_LATENCY, 4, clocks from converter din_valid to dout_valid
INT_WIDTH, 8, bits per colour channel / grayscale sample

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to process one frame; ignored unless state IDLE
abort  in  1  stop the current frame; wins over start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, frame fully written
src_rd_en  out  1  source RAM read enable (registered)
src_addr  out  ADDR_WIDTH  source RAM read address (registered)
src_rdata  in  3*INT_WIDTH  {R,G,B}, valid the cycle after src_rd_en
conv_r, conv_g, conv_b  out  INT_WIDTH each  slices of src_rdata, passed through combinationally
conv_din_valid  out  1  src_rd_en delayed one cycle
conv_gray  in  INT_WIDTH  converter result
conv_dout_valid  in  1  converter result valid
dst_wr_en  out  1  destination RAM write enable (registered)
dst_addr  out  ADDR_WIDTH  destination write address (registered)
dst_wdata  out  INT_WIDTH  conv_gray registered

Behaviour:
- NPIX = IMG_WIDTH*IMG_HEIGHT. States: FLUSH, IDLE, RUN, DRAIN, DONE.
- Reset (async, rst_n=0): state=FLUSH, flush counter=0, rd_cnt=wr_cnt=0, all outputs 0 except busy=1.
- FLUSH: src_rd_en=0 and dst_wr_en forced 0; conv_dout_valid ignored. After PIPE_LATENCY+1 cycles go to IDLE. start is ignored.
- IDLE: when start=1 and abort=0, clear rd_cnt/wr_cnt and go to RUN. src_rd_en=1 with src_addr=0 in the next cycle.
- RUN: src_rd_en=1 every cycle, src_addr=rd_cnt, rd_cnt++. After issuing address NPIX-1, go to DRAIN and drop src_rd_en the following cycle. No stalls: the converter cannot stall.
- RUN/DRAIN write path: on conv_dout_valid=1, next cycle dst_wr_en=1, dst_addr=wr_cnt, dst_wdata=conv_gray, and wr_cnt++.
- Writes are suppressed once wr_cnt==NPIX, so there are never more than NPIX writes.
- DRAIN: when the write of address NPIX-1 is issued, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle that done falls.
- Latency for start sampled at edge 0:
  - src_rd_en high cycles 1..NPIX
  - conv_din_valid cycles 2..NPIX+1
  - conv_dout_valid cycles 6..NPIX+5
  - dst_wr_en cycles 7..NPIX+6
  - done at cycle NPIX+7
- abort in RUN, DRAIN or DONE: next cycle state=FLUSH, src_rd_en=0, dst_wr_en=0, done not pulsed. In-flight converter results are discarded and the flush length is PIPE_LATENCY+1. abort in IDLE or FLUSH has no effect.
- start and abort both high: abort wins; no frame starts.
- start while busy is dropped, not queued.
- Counters are ADDR_WIDTH bits; no wrap-around occurs because of the NPIX terminal compare.
- NPIX=1 is legal: a single read, then DRAIN directly, done at cycle 8.

Test Plan:
1. Reset release, start at the first IDLE cycle, 4x2 frame with src = {R,G,B} = {8'd200,8'd100,8'd50} at all addresses. Required: 8 writes at dst_addr 0..7, each dst_wdata=8'd107, done pulse at cycle 15 after start, busy low afterwards.
2. Post-reset flush: hold start=1 continuously from reset release. Required: busy=1 and no reads for 5 cycles, then the frame starts from IDLE.
3. Pattern frame with src[i] = {i*30, i*20, i*10}. Required: dst[i] equals the converter's arithmetic result for each pixel, written in ascending address order with no gaps.
4. abort two cycles into RUN. Required: src_rd_en low next cycle, zero dst writes, no done, busy=1 for 5 flush cycles. A new start then completes a full 8-write frame.
5. start pulsed during RUN, and start+abort asserted together in IDLE. Required: the running frame is unaffected and exactly one frame completes; the simultaneous pulse starts nothing.
6. IMG_WIDTH=1, IMG_HEIGHT=1. Required: single read at addr 0, single write at addr 0, done at cycle 8.

Source files
------------

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the RGB-to-grayscale converter: streams one frame from the
// source RAM through the converter and writes the results to the destination RAM.
module gray_frame_ctrl #(
    parameter int unsigned IMG_WIDTH    = 4,
    parameter int unsigned IMG_HEIGHT   = 2,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned PIPE_LATENCY = 4,
    parameter int unsigned INT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   src_rd_en,
    output logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [3*INT_WIDTH-1:0] src_rdata,
    output logic [INT_WIDTH-1:0]   conv_r,
    output logic [INT_WIDTH-1:0]   conv_g,
    output logic [INT_WIDTH-1:0]   conv_b,
    output logic                   conv_din_valid,
    input  logic [INT_WIDTH-1:0]   conv_gray,
    input  logic                   conv_dout_valid,
    output logic                   dst_wr_en,
    output logic [ADDR_WIDTH-1:0]  dst_addr,
    output logic [INT_WIDTH-1:0]   dst_wdata
);

    localparam int unsigned NPIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned FLUSH_W = $clog2(PIPE_LATENCY + 1) + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] NPIX_A     = ADDR_WIDTH'(NPIX);
    localparam logic [FLUSH_W-1:0]    FLUSH_LAST = FLUSH_W'(PIPE_LATENCY);

    typedef enum logic [2:0] {
        S_FLUSH = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state, state_d;
    logic [FLUSH_W-1:0]      flush_cnt, flush_cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_cnt, rd_cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_cnt, wr_cnt_d;
    logic                    busy_d, done_d, src_rd_en_d, dst_wr_en_d;
    logic [ADDR_WIDTH-1:0]   src_addr_d, dst_addr_d;
    logic [INT_WIDTH-1:0]    dst_wdata_d;
    logic                    active;

    assign conv_r = src_rdata[3*INT_WIDTH-1 -: INT_WIDTH];
    assign conv_g = src_rdata[2*INT_WIDTH-1 -: INT_WIDTH];
    assign conv_b = src_rdata[INT_WIDTH-1 -: INT_WIDTH];

    assign active = (state == S_RUN) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_FLUSH;
            flush_cnt      <= '0;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            src_rd_en      <= 1'b0;
            src_addr       <= '0;
            conv_din_valid <= 1'b0;
            dst_wr_en      <= 1'b0;
            dst_addr       <= '0;
            dst_wdata      <= '0;
        end else begin
            state          <= state_d;
            flush_cnt      <= flush_cnt_d;
            rd_cnt         <= rd_cnt_d;
            wr_cnt         <= wr_cnt_d;
            busy           <= busy_d;
            done           <= done_d;
            src_rd_en      <= src_rd_en_d;
            src_addr       <= src_addr_d;
            conv_din_valid <= src_rd_en;
            dst_wr_en      <= dst_wr_en_d;
            dst_addr       <= dst_addr_d;
            dst_wdata      <= dst_wdata_d;
        end
    end

    always_comb begin
        state_d     = state;
        flush_cnt_d = flush_cnt;
        rd_cnt_d    = rd_cnt;
        wr_cnt_d    = wr_cnt;
        src_rd_en_d = 1'b0;
        src_addr_d  = src_addr;
        dst_wr_en_d = 1'b0;
        dst_addr_d  = dst_addr;
        dst_wdata_d = dst_wdata;

        case (state)
            S_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_d = S_IDLE;
                else                         flush_cnt_d = flush_cnt + FLUSH_W'(1);
            end
            S_IDLE: begin
                if (start && !abort) begin
                    src_rd_en_d = 1'b1;
                    src_addr_d  = '0;
                    rd_cnt_d    = ADDR_WIDTH'(1);
                    wr_cnt_d    = '0;
                    state_d     = (NPIX == 32'd1) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                src_rd_en_d = 1'b1;
                src_addr_d  = rd_cnt;
                rd_cnt_d    = rd_cnt + ADDR_WIDTH'(1);
                if (rd_cnt == LAST_ADDR) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wr_cnt == NPIX_A) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_FLUSH;
                flush_cnt_d = '0;
            end
        endcase

        // Result capture; the terminal compare caps the frame at NPIX writes
        if (active && conv_dout_valid && (wr_cnt != NPIX_A)) begin
            dst_wr_en_d = 1'b1;
            dst_addr_d  = wr_cnt;
            dst_wdata_d = conv_gray;
            wr_cnt_d    = wr_cnt + ADDR_WIDTH'(1);
        end

        // Abort discards in-flight results by re-flushing the converter
        if (abort && (active || (state == S_DONE))) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
            rd_cnt_d    = rd_cnt;
            wr_cnt_d    = wr_cnt;
            src_rd_en_d = 1'b0;
            src_addr_d  = src_addr;
            dst_wr_en_d = 1'b0;
            dst_addr_d  = dst_addr;
            dst_wdata_d = dst_wdata;
        end

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Bench for gray_frame_ctrl: a 4x2 and a 1x1 instance, each with a source RAM and a
// 4-stage converter model; writes and done pulses are checked against a scoreboard.
module tb_gray_frame_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 8;

    typedef struct packed {
        logic [31:0] at_edge;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // ---------------- instance A: 4x2 ----------------
    logic          start_a, abort_a, busy_a, done_a, src_rd_en_a;
    logic [AW-1:0] src_addr_a, dst_addr_a;
    logic [3*IW-1:0] src_rdata_a = '0;
    logic [IW-1:0] conv_r_a, conv_g_a, conv_b_a, conv_gray_a, dst_wdata_a;
    logic          conv_din_valid_a, conv_dout_valid_a, dst_wr_en_a;
    logic [3*IW-1:0] mem_a [8];
    logic [8:0]    pipe_a [4] = '{default: '0};

    gray_frame_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .src_rd_en(src_rd_en_a), .src_addr(src_addr_a),
        .src_rdata(src_rdata_a), .conv_r(conv_r_a), .conv_g(conv_g_a), .conv_b(conv_b_a),
        .conv_din_valid(conv_din_valid_a), .conv_gray(conv_gray_a),
        .conv_dout_valid(conv_dout_valid_a), .dst_wr_en(dst_wr_en_a),
        .dst_addr(dst_addr_a), .dst_wdata(dst_wdata_a)
    );

    // ---------------- instance B: 1x1 ----------------
    logic          start_b, abort_b, busy_b, done_b, src_rd_en_b;
    logic [AW-1:0] src_addr_b, dst_addr_b;
    logic [3*IW-1:0] src_rdata_b = '0;
    logic [IW-1:0] conv_r_b, conv_g_b, conv_b_b, conv_gray_b, dst_wdata_b;
    logic          conv_din_valid_b, conv_dout_valid_b, dst_wr_en_b;
    logic [3*IW-1:0] mem_b;
    logic [8:0]    pipe_b [4] = '{default: '0};

    gray_frame_ctrl #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .src_rd_en(src_rd_en_b), .src_addr(src_addr_b),
        .src_rdata(src_rdata_b), .conv_r(conv_r_b), .conv_g(conv_g_b), .conv_b(conv_b_b),
        .conv_din_valid(conv_din_valid_b), .conv_gray(conv_gray_b),
        .conv_dout_valid(conv_dout_valid_b), .dst_wr_en(dst_wr_en_b),
        .dst_addr(dst_addr_b), .dst_wdata(dst_wdata_b)
    );

    // Converter arithmetic: weighted sum with weights totalling 256
    function automatic logic [7:0] gray8(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
        int unsigned s;
        s = 32'(r) * 64 + 32'(g) * 104 + 32'(b) * 88;
        return 8'(s >> 8);
    endfunction

    // Synchronous-read RAMs and 4-stage converter pipelines (no reset, like the real one)
    always @(posedge clk) begin
        if (src_rd_en_a) src_rdata_a <= mem_a[src_addr_a[2:0]];
        if (src_rd_en_b) src_rdata_b <= mem_b;
        pipe_a[0] <= {conv_din_valid_a, gray8(conv_r_a, conv_g_a, conv_b_a)};
        pipe_b[0] <= {conv_din_valid_b, gray8(conv_r_b, conv_g_b, conv_b_b)};
        for (int i = 1; i < 4; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign conv_dout_valid_a = pipe_a[3][8];
    assign conv_gray_a       = pipe_a[3][7:0];
    assign conv_dout_valid_b = pipe_b[3][8];
    assign conv_gray_b       = pipe_b[3][7:0];

    // ---------------- scoreboard ----------------
    wr_exp_t     q_wr_a[$], q_wr_b[$];
    int unsigned q_done_a[$], q_done_b[$], q_rd_b[$];
    logic [7:0]  exp_gray_a [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] val);
        checks++;
        errors++;
        $display("FAIL %s: got event with value %0d at edge %0d, expected none", name, val, edge_cnt);
    endtask

    always @(negedge clk) begin : mon_a
        wr_exp_t     e;
        int unsigned d;
        if (rst_n) begin
            if (dst_wr_en_a) begin
                if (q_wr_a.size() == 0) unexpected("a_write", 32'(dst_addr_a));
                else begin
                    e = q_wr_a.pop_front();
                    check("a_wr_addr", 32'(dst_addr_a), 32'(e.addr));
                    check("a_wr_data", 32'(dst_wdata_a), 32'(e.data));
                    check("a_wr_edge", edge_cnt, e.at_edge);
                end
            end
            if (done_a) begin
                if (q_done_a.size() == 0) unexpected("a_done", edge_cnt);
                else begin
                    d = q_done_a.pop_front();
                    check("a_done_edge", edge_cnt, d);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        wr_exp_t     e;
        int unsigned d;
        if (rst_n) begin
            if (src_rd_en_b) begin
                if (q_rd_b.size() == 0) unexpected("b_read", 32'(src_addr_b));
                else begin
                    d = q_rd_b.pop_front();
                    check("b_rd_edge", edge_cnt, d);
                    check("b_rd_addr", 32'(src_addr_b), 0);
                end
            end
            if (dst_wr_en_b) begin
                if (q_wr_b.size() == 0) unexpected("b_write", 32'(dst_addr_b));
                else begin
                    e = q_wr_b.pop_front();
                    check("b_wr_addr", 32'(dst_addr_b), 32'(e.addr));
                    check("b_wr_data", 32'(dst_wdata_b), 32'(e.data));
                    check("b_wr_edge", edge_cnt, e.at_edge);
                end
            end
            if (done_b) begin
                if (q_done_b.size() == 0) unexpected("b_done", edge_cnt);
                else begin
                    d = q_done_b.pop_front();
                    check("b_done_edge", edge_cnt, d);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // e0 is the edge that samples start: writes land on cycles 7..14, done on cycle 15
    task automatic push_frame_a(input int unsigned e0);
        for (int i = 0; i < 8; i++)
            q_wr_a.push_back('{at_edge: 32'(e0 + 6 + i), addr: 16'(i), data: exp_gray_a[i]});
        q_done_a.push_back(e0 + 14);
    endtask

    task automatic start_frame_a(input bit track, output int unsigned e0);
        start_a = 1'b1;
        e0 = edge_cnt + 1;
        if (track) push_frame_a(e0);
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int unsigned e0, input string tag);
        int n = 0;
        while (busy_a && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_busy_fall_edge"}, edge_cnt, e0 + 15);
        check({tag, "_done_low_at_idle"}, 32'(done_a), 0);
    endtask

    task automatic load_pattern_a();
        logic [7:0] tbl [8];
        tbl = '{8'd0, 8'd19, 8'd38, 8'd57, 8'd76, 8'd95, 8'd114, 8'd133};
        for (int i = 0; i < 8; i++) begin
            mem_a[i]      = {8'(i * 30), 8'(i * 20), 8'(i * 10)};
            exp_gray_a[i] = tbl[i];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at edge %0d", edge_cnt);
        $fatal(1);
    end

    initial begin
        int unsigned e0, rel;
        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        mem_b   = {8'd10, 8'd20, 8'd30};
        for (int i = 0; i < 8; i++) begin
            mem_a[i]      = {8'd200, 8'd100, 8'd50};
            exp_gray_a[i] = 8'd107;
        end
        repeat (3) tick();

        // Reset state
        check("rst_busy", 32'(busy_a), 1);
        check("rst_done", 32'(done_a), 0);
        check("rst_rd_en", 32'(src_rd_en_a), 0);
        check("rst_wr_en", 32'(dst_wr_en_a), 0);
        check("rst_din_valid", 32'(conv_din_valid_a), 0);
        check("rst_busy_b", 32'(busy_b), 1);

        // Post-reset flush with start held, then the constant-colour frame
        start_a = 1'b1;
        rst_n   = 1'b1;
        rel     = edge_cnt;
        for (int k = 0; k < 5; k++) begin
            check("flush_busy", 32'(busy_a), 1);
            check("flush_no_read", 32'(src_rd_en_a), 0);
            tick();
        end
        check("idle_after_flush", 32'(busy_a), 0);
        e0 = rel + 6;
        push_frame_a(e0);
        tick();
        start_a = 1'b0;
        check("first_rd_en", 32'(src_rd_en_a), 1);
        check("first_rd_addr", 32'(src_addr_a), 0);
        wait_idle_a(e0, "const");

        // Pattern frame
        load_pattern_a();
        tick();
        start_frame_a(1'b1, e0);
        wait_idle_a(e0, "pattern");

        // Abort two cycles into RUN
        tick();
        start_frame_a(1'b0, e0);
        tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("abort_flush_busy", 32'(busy_a), 1);
            check("abort_no_read", 32'(src_rd_en_a), 0);
            tick();
        end
        check("abort_idle", 32'(busy_a), 0);
        repeat (10) tick();
        start_frame_a(1'b1, e0);
        wait_idle_a(e0, "after_abort");

        // start during RUN is dropped
        tick();
        start_frame_a(1'b1, e0);
        repeat (3) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_idle_a(e0, "start_in_run");
        repeat (3) tick();
        check("no_queued_frame", 32'(busy_a), 0);

        // start and abort together in IDLE start nothing
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("start_abort_busy", 32'(busy_a), 0);
        check("start_abort_no_read", 32'(src_rd_en_a), 0);
        repeat (20) tick();
        check("start_abort_still_idle", 32'(busy_a), 0);

        // Single-pixel frame on instance B: gray(10,20,30) = 20, done on cycle 8
        start_b = 1'b1;
        e0 = edge_cnt + 1;
        q_rd_b.push_back(e0);
        q_wr_b.push_back('{at_edge: 32'(e0 + 6), addr: 16'd0, data: 8'd20});
        q_done_b.push_back(e0 + 7);
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 100 && busy_b; n++) tick();
        check("b_busy_fall_edge", edge_cnt, e0 + 8);

        repeat (5) tick();
        check("a_writes_left", 32'(q_wr_a.size()), 0);
        check("a_dones_left", 32'(q_done_a.size()), 0);
        check("b_reads_left", 32'(q_rd_b.size()), 0);
        check("b_writes_left", 32'(q_wr_b.size()), 0);
        check("b_dones_left", 32'(q_done_b.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
